// File: rtl/neck_angle_filter_pkg.sv
// Shared constants for the neck-angle filter: sample width and alarm FSM encoding.
package neck_angle_filter_pkg;

    localparam int unsigned SampleW = 12;

    // Alarm FSM encoding
    localparam logic [1:0] StNormal  = 2'd0;
    localparam logic [1:0] StPendOn  = 2'd1;
    localparam logic [1:0] StAlarm   = 2'd2;
    localparam logic [1:0] StPendOff = 2'd3;

endpackage

// File: rtl/neck_angle_filter_if.sv
// Sample bus from the ADC capture controller into the filter.
interface neck_angle_filter_if;
    import neck_angle_filter_pkg::*;

    logic                      adc_finish;
    logic signed [SampleW:0]   adc_data;

    modport master (output adc_finish, output adc_data);
    modport slave  (input  adc_finish, input  adc_data);

endinterface

// File: rtl/neck_angle_filter_moving_avg_core.sv
// Moving-average core: ring buffer, running sum, warm-up counter and avg_valid pulse.
module moving_avg_core
    import neck_angle_filter_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_strobe,
    input  logic [SampleW-1:0] i_sample,
    output logic [SampleW-1:0] o_avg,
    output logic               o_valid
);

    localparam int unsigned DEPTH  = 1 << AVG_LOG2;
    localparam int unsigned SUM_W  = SampleW + AVG_LOG2;
    localparam int unsigned FILL_W = AVG_LOG2 + 1;

    logic [SampleW-1:0]  r_buf [DEPTH];
    logic [SUM_W-1:0]    r_sum;
    logic [AVG_LOG2-1:0] r_wr_ptr;
    logic [FILL_W-1:0]   r_fill;
    logic                r_acc;
    logic [SampleW-1:0]  r_avg;
    logic                r_valid;

    logic                w_full;
    logic [SUM_W-1:0]    w_sum_next;

    assign w_full     = (r_fill == FILL_W'(DEPTH));
    // Old entry is read before it is overwritten; sum stays non-negative since buffer resets to 0
    assign w_sum_next = r_sum + SUM_W'(i_sample) - SUM_W'(r_buf[r_wr_ptr]);

    // Ring-buffer write on accept, then register the average one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
            r_sum    <= '0;
            r_wr_ptr <= '0;
            r_fill   <= '0;
            r_acc    <= 1'b0;
            r_avg    <= '0;
            r_valid  <= 1'b0;
        end else if (i_en) begin
            r_acc   <= i_strobe;
            r_valid <= r_acc && w_full;
            if (r_acc && w_full) begin
                // Top SampleW bits of the sum == sum >> AVG_LOG2
                r_avg <= r_sum[SUM_W-1 -: SampleW];
            end
            if (i_strobe) begin
                r_buf[r_wr_ptr] <= i_sample;
                r_sum           <= w_sum_next;
                r_wr_ptr        <= r_wr_ptr + AVG_LOG2'(1);
                if (!w_full) begin
                    r_fill <= r_fill + FILL_W'(1);
                end
            end
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_avg   = r_avg;
    assign o_valid = r_valid;

endmodule

// File: rtl/neck_angle_filter.sv
// Per-channel posture filter: moving average followed by a hysteresis/debounce alarm FSM.
module neck_angle_filter
    import neck_angle_filter_pkg::*;
#(
    parameter int unsigned        AVG_LOG2 = 3,
    parameter logic [SampleW-1:0] TH_HIGH  = 12'd2500,
    parameter logic [SampleW-1:0] TH_LOW   = 12'd2300,
    parameter int unsigned        DEBOUNCE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    neck_angle_filter_if.slave   adc_if,
    output logic [SampleW-1:0]   o_avg_data,
    output logic                 o_avg_valid,
    output logic                 o_alarm,
    output logic                 o_alarm_rise
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    logic [SampleW-1:0] w_sample;
    logic               w_hi;
    logic               w_lo;
    logic [3:0]         w_cnt_inc;
    logic [1:0]         w_state_d;
    logic [3:0]         w_cnt_d;
    logic               w_alarm_d;

    logic [1:0]         r_state;
    logic [3:0]         r_cnt;
    logic               r_alarm;
    logic               r_alarm_rise;

    // Out-of-range samples (bit 12 set) clamp to zero
    assign w_sample = adc_if.adc_data[SampleW] ? '0 : adc_if.adc_data[SampleW-1:0];

    moving_avg_core #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_en     (i_en),
        .i_strobe (adc_if.adc_finish),
        .i_sample (w_sample),
        .o_avg    (o_avg_data),
        .o_valid  (o_avg_valid)
    );

    assign w_hi      = (o_avg_data >= TH_HIGH);
    assign w_lo      = (o_avg_data <= TH_LOW);
    assign w_cnt_inc = r_cnt + 4'd1;

    // Next-state logic: the FSM only advances on a fresh average
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        if (o_avg_valid) begin
            unique case (r_state)
                StNormal: begin
                    if (w_hi) begin
                        w_cnt_d   = (DEB == 4'd1) ? 4'd0 : 4'd1;
                        w_state_d = (DEB == 4'd1) ? StAlarm : StPendOn;
                    end
                end
                StPendOn: begin
                    if (!w_hi) begin
                        w_state_d = StNormal;
                        w_cnt_d   = 4'd0;
                    end else if (w_cnt_inc == DEB) begin
                        w_state_d = StAlarm;
                        w_cnt_d   = 4'd0;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
                StAlarm: begin
                    if (w_lo) begin
                        w_cnt_d   = (DEB == 4'd1) ? 4'd0 : 4'd1;
                        w_state_d = (DEB == 4'd1) ? StNormal : StPendOff;
                    end
                end
                StPendOff: begin
                    if (!w_lo) begin
                        w_state_d = StAlarm;
                        w_cnt_d   = 4'd0;
                    end else if (w_cnt_inc == DEB) begin
                        w_state_d = StNormal;
                        w_cnt_d   = 4'd0;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_d = StNormal;
                    w_cnt_d   = 4'd0;
                end
            endcase
        end
    end

    assign w_alarm_d = (w_state_d == StAlarm) || (w_state_d == StPendOff);

    // FSM state, alarm level and rise pulse; frozen while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StNormal;
            r_cnt        <= 4'd0;
            r_alarm      <= 1'b0;
            r_alarm_rise <= 1'b0;
        end else if (i_en) begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_alarm      <= w_alarm_d;
            r_alarm_rise <= w_alarm_d && !r_alarm;
        end else begin
            r_alarm_rise <= 1'b0;
        end
    end

    assign o_alarm      = r_alarm;
    assign o_alarm_rise = r_alarm_rise;

endmodule

// File: tb/tb_neck_angle_filter.sv
// Self-checking bench for neck_angle_filter against a queue-based reference model.
module tb_neck_angle_filter;

    localparam int DEPTH = 8;
    localparam int THH   = 2500;
    localparam int THL   = 2300;
    localparam int DEB   = 4;
    localparam int NB    = 12;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] avg_data;
    logic        avg_valid;
    logic        alarm;
    logic        alarm_rise;

    neck_angle_filter_if u_if ();

    neck_angle_filter dut (
        .clk          (clk),
        .rst          (rst),
        .i_en         (en),
        .adc_if       (u_if),
        .o_avg_data   (avg_data),
        .o_avg_valid  (avg_valid),
        .o_alarm      (alarm),
        .o_alarm_rise (alarm_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int q[$];
    int m_cnt;
    int m_avg;
    bit m_valid;
    bit m_alarm;
    bit m_rise;
    int m_run;

    function automatic void m_reset();
        q.delete();
        m_cnt   = 0;
        m_avg   = 0;
        m_valid = 0;
        m_alarm = 0;
        m_rise  = 0;
        m_run   = 0;
    endfunction

    function automatic void m_accept(input logic [12:0] d);
        int s;
        int sum;
        s = d[12] ? 0 : int'(d[11:0]);
        q.push_back(s);
        if (q.size() > DEPTH) void'(q.pop_front());
        m_cnt++;
        m_valid = 0;
        if (m_cnt >= DEPTH) begin
            sum = 0;
            foreach (q[i]) sum += q[i];
            m_avg   = sum / DEPTH;
            m_valid = 1;
        end
    endfunction

    // Alarm toggles after DEB consecutive averages on the far side of the active threshold
    function automatic void m_fsm();
        bit qual;
        m_rise = 0;
        if (!m_valid) return;
        qual = m_alarm ? (m_avg <= THL) : (m_avg >= THH);
        if (qual) m_run++;
        else m_run = 0;
        if (m_run == DEB) begin
            m_alarm = !m_alarm;
            m_run   = 0;
            m_rise  = m_alarm;
        end
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_avg"}, int'(avg_data), 0);
        chk({tag, "_valid"}, int'(avg_valid), 0);
        chk({tag, "_alarm"}, int'(alarm), 0);
        chk({tag, "_rise"}, int'(alarm_rise), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        u_if.adc_finish = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    // One isolated strobe; checks the average at k+1 and the alarm at k+2
    task automatic send(input logic [12:0] d, input logic e);
        @(negedge clk);
        en = e;
        u_if.adc_finish = 1'b1;
        u_if.adc_data   = d;
        @(negedge clk);
        u_if.adc_finish = 1'b0;
        if (e) m_accept(d);
        else m_valid = 0;
        @(negedge clk);
        chk("avg_valid", int'(avg_valid), int'(m_valid));
        chk("avg_data", int'(avg_data), m_avg);
        m_fsm();
        @(negedge clk);
        chk("valid_pulse_end", int'(avg_valid), 0);
        chk("alarm", int'(alarm), int'(m_alarm));
        chk("alarm_rise", int'(alarm_rise), int'(m_rise));
        en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [12:0] d;
        logic        e;
        logic [12:0] bd [NB];
        bit          ev [NB+1];
        int          ea [NB+1];
        int          base;

        rst = 1'b1;
        en  = 1'b1;
        u_if.adc_finish = 1'b0;
        u_if.adc_data   = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        m_reset();

        // Warm-up at 1000
        repeat (8) send(13'd1000, 1'b1);
        chk("warm_avg", int'(avg_data), 1000);

        // Rising to 3000: alarm on the 9th high sample
        repeat (9) send(13'd3000, 1'b1);
        chk("alarm_on", int'(alarm), 1);

        // Between thresholds: alarm holds
        repeat (16) send(13'd2400, 1'b1);
        chk("alarm_hold", int'(alarm), 1);

        // Below TH_LOW: alarm drops
        repeat (12) send(13'd2000, 1'b1);
        chk("alarm_off", int'(alarm), 0);

        // Debounce break: three highs then 2499
        repeat (9) send(13'd2600, 1'b1);
        send(13'd1792, 1'b1);
        chk("break_avg", int'(avg_data), 2499);
        chk("break_alarm", int'(alarm), 0);
        repeat (12) send(13'd2600, 1'b1);
        chk("rearm_alarm", int'(alarm), 1);

        // Clamp of bit-12 samples, then disabled strobes
        do_reset();
        chk_zero("reset2");
        repeat (8) send(13'h1FFF, 1'b1);
        chk("clamp_avg", int'(avg_data), 0);
        repeat (4) send(13'd3000, 1'b0);
        chk("en_low_avg", int'(avg_data), 0);

        // Reset in the same cycle as a strobe during warm-up
        do_reset();
        repeat (5) send(13'd1000, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        u_if.adc_finish = 1'b1;
        u_if.adc_data   = 13'd1000;
        @(negedge clk);
        rst = 1'b0;
        u_if.adc_finish = 1'b0;
        m_reset();
        chk_zero("rst_strobe");
        repeat (8) send(13'd1000, 1'b1);

        // Randomised phases alternating around the thresholds
        for (int p = 0; p < 6; p++) begin
            base = (p % 2 == 0) ? 2900 : 1900;
            for (int i = 0; i < 14; i++) begin
                d = 13'(base + $urandom_range(0, 400) - 200);
                if ($urandom_range(0, 9) == 0) d[12] = 1'b1;
                e = ($urandom_range(0, 7) != 0);
                send(d, e);
            end
        end

        // Back-to-back strobes every cycle
        for (int i = 0; i < NB; i++) begin
            bd[i] = 13'($urandom_range(1800, 3300));
            m_accept(bd[i]);
            ev[i] = m_valid;
            ea[i] = m_avg;
            m_fsm();
        end
        ev[NB] = 0;
        ea[NB] = m_avg;
        for (int j = 0; j <= NB + 2; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                chk("burst_valid", int'(avg_valid), int'(ev[j-2]));
                chk("burst_avg", int'(avg_data), ea[j-2]);
            end
            u_if.adc_finish = (j < NB);
            if (j < NB) u_if.adc_data = bd[j];
        end
        repeat (3) @(negedge clk);
        chk("burst_alarm", int'(alarm), int'(m_alarm));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/neck_angle_filter.md
# neck_angle_filter

Downstream consumer of the ADS7883 capture controller: takes each 12-bit sample strobed by the controller and runs it through an N-deep moving-average filter. The filtered value feeds a hysteresis + debounce state machine that raises a posture alarm. Output goes to the display/alert logic; one instance per ADC channel.

## Interface
Parameters:
- AVG_LOG2, 3: log2 of averaging depth (DEPTH = 2^AVG_LOG2, legal 1..5).
- TH_HIGH, 12'd2500: alarm-on threshold (avg >= TH_HIGH counts as high).
- TH_LOW, 12'd2300: alarm-off threshold (avg <= TH_LOW counts as low). Requires TH_LOW < TH_HIGH.
- DEBOUNCE, 4: consecutive qualifying averages needed to change alarm state (legal 1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  filter enable; low = strobes ignored, all state held.
- adc_finish  in  1  one-cycle sample strobe from the ADC controller.
- adc_data  in  13 signed  sample; bit 12 always 0 in normal use.
- avg_data  out  12  current filtered value.
- avg_valid  out  1  one-cycle pulse; avg_data updated.
- alarm  out  1  posture alarm level.
- alarm_rise  out  1  one-cycle pulse on alarm 0->1.

## Operation
- Sample accept: adc_finish && en at a rising edge. If adc_data[12]=1 the sample is treated as 0 (clamp), else adc_data[11:0].
- Buffer: DEPTH x 12-bit register ring, wr_ptr wraps DEPTH-1 -> 0. On accept: write the sample at wr_ptr, sum <= sum + new - buf[wr_ptr] (old value read before overwrite), wr_ptr++.
- sum width 12+AVG_LOG2 bits, unsigned. It never overflows because all buffer entries reset to 0.
- Average: avg = sum >> AVG_LOG2 (truncating).
- Warm-up: fill counter saturates at DEPTH. avg_valid is suppressed until DEPTH samples have been accepted. The first pulse follows the DEPTH-th sample.
- Alarm FSM states: NORMAL, PEND_ON, ALARM, PEND_OFF. It steps only on cycles where avg_valid=1, using avg_data.
  - NORMAL: avg>=TH_HIGH → cnt=1. Go to ALARM if DEBOUNCE==1, else PEND_ON.
  - PEND_ON: avg>=TH_HIGH → cnt++. When cnt reaches DEBOUNCE → ALARM. Otherwise (avg<TH_HIGH) → NORMAL, cnt=0.
  - ALARM: avg<=TH_LOW → cnt=1, then PEND_OFF (or NORMAL if DEBOUNCE==1).
  - PEND_OFF: avg<=TH_LOW → cnt++. When cnt reaches DEBOUNCE → NORMAL. Otherwise → ALARM, cnt=0.
- alarm=1 in ALARM and PEND_OFF. alarm_rise pulses on the cycle alarm goes 0→1.
- en low mid-stream: no writes, no pulses, FSM frozen. Resumes where it stopped.
- rst at any time: everything returns to reset values on the next edge, including a strobe arriving in the same cycle. The warm-up restarts.

## Timing
- Reset values: avg_data=0, avg_valid=0, alarm=0, alarm_rise=0. Buffer, sum, wr_ptr, fill count and cnt are 0. FSM is in NORMAL.
- Strobe sampled at edge k: buffer, sum and ptr update at edge k. avg_data/avg_valid register at edge k+1, so avg_valid is high during cycle k+1..k+2. FSM/alarm/alarm_rise update at edge k+2.
- Back-to-back strobes (every cycle) are fully supported, giving one avg_valid pulse per accepted sample after warm-up. Nominal strobe spacing is 69 clk.

## Structure
- Shared package: FSM state encoding (NORMAL/PEND_ON/ALARM/PEND_OFF) and the 12-bit sample width constant.
- One sub-module is natural: moving_avg_core (ring buffer, running sum, warm-up counter, avg_valid). The FSM lives in the top level.

## Test plan
Defaults apply (DEPTH=8, 2500/2300, DEBOUNCE=4).
- Reset, then 8 strobes of 1000 → no avg_valid on strobes 1–7. On strobe 8, avg_valid pulses with avg_data=1000, alarm=0.
- Warm at 1000, then repeated 3000 → averages 1250, 1500, …, 3000. Averages reach ≥2500 on the 6th 3000-sample. alarm and a single alarm_rise follow the 9th 3000-sample's average (4th consecutive high).
- In ALARM, feed 2400 steady → averages settle at 2400 (between thresholds); alarm stays 1 indefinitely. Then feed 2000 → alarm drops after the 4th consecutive average ≤2300.
- Debounce break: three high averages then one at 2499 → FSM back to NORMAL. Then four highs are needed again before alarm.
- adc_data=13'h1FFF (bit 12 set) ×8 after reset → treated as 0, avg_data=0. Also: strobes with en=0 produce no avg_valid and don't change avg_data.
- Assert rst during warm-up after 5 strobes, in the same cycle as a strobe → all outputs 0. A fresh 8 strobes are needed before the first avg_valid.
